// File: rtl/mac_pkg.sv
// ============================================================================
// mac_pkg : shared state encoding and default widths for mac_seq_acc
// Rev 1.0
// ============================================================================
`default_nettype none

package mac_pkg;

  localparam int N_DEF     = 4;
  localparam int ACC_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } mac_state_t;

endpackage

`default_nettype wire

// File: rtl/mac_shift_add.sv
// ============================================================================
// mac_shift_add : operand registers and one conditional shift-add per step
// Rev 1.0
// ============================================================================
`default_nettype none

module mac_shift_add
  import mac_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             load,
  input  logic             step,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [CNT_W-1:0] cnt,
  output logic [2*N-1:0]   product
);

  logic [N-1:0]   r_mcand;
  logic [N-1:0]   r_mplier;
  logic [2*N-1:0] r_prod;
  logic [2*N-1:0] w_addend;

  // Multiplicand weight for this step comes from the controller's bit counter.
  assign w_addend = (2*N)'(r_mcand) << cnt;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else if (load) begin
      r_mcand  <= a;
      r_mplier <= b;
      r_prod   <= '0;
    end else if (step) begin
      if (r_mplier[0]) begin
        r_prod <= r_prod + w_addend;
      end
      r_mplier <= r_mplier >> 1;
    end
  end

  assign product = r_prod;

endmodule

`default_nettype wire

// File: rtl/mac_seq_acc.sv
// ============================================================================
// mac_seq_acc : sequential shift-and-add multiply with wide wrapping accumulator
// Rev 1.0
// ============================================================================
`default_nettype none

module mac_seq_acc
  import mac_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             start,
  input  logic             clr_acc,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(N - 1);

  mac_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_load;
  logic             w_step;
  logic [2*N-1:0]   w_product;
  logic [ACC_W:0]   w_sum;

  assign w_load = (r_state == IDLE) && start;
  assign w_step = (r_state == MUL);

  mac_shift_add #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_shift_add (
    .CLK     (CLK),
    .CLR     (CLR),
    .load    (w_load),
    .step    (w_step),
    .a       (a),
    .b       (b),
    .cnt     (r_cnt),
    .product (w_product)
  );

  // Extra top bit of the sum is the carry that sets the sticky overflow.
  assign w_sum = {1'b0, r_acc} + (ACC_W + 1)'(w_product);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clr_acc) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end
          if (start) begin
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= MUL;
          end
        end
        MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state <= ACC;
          end
        end
        ACC: begin
          r_acc <= w_sum[ACC_W-1:0];
          if (w_sum[ACC_W]) begin
            r_ovf <= 1'b1;
          end
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign acc_out = r_acc;
  assign ovf     = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mac_seq_acc.sv
// ============================================================================
// tb_mac_seq_acc : directed self-checking bench for mac_seq_acc
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mac_seq_acc;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        start = 1'b0;
  logic        clr_acc = 1'b0;
  logic [3:0]  a = '0;
  logic [3:0]  b = '0;
  logic        busy;
  logic        done;
  logic [11:0] acc_out;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;

  mac_seq_acc #(.N(4), .ACC_W(12)) dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .start   (start),
    .clr_acc (clr_acc),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .acc_out (acc_out),
    .ovf     (ovf)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, run did not complete");
    $fatal(1, "watchdog");
  end

  // Runs one operation; cycle k is the cycle after the k-th edge following acceptance.
  // Operands are scrambled right after acceptance; start is re-asserted in cycle restart_at.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tclr,
                        input int restart_at, output int busy_cyc, output int done_cnt,
                        output int done_at, output logic [11:0] acc_at_done);
    busy_cyc = 0; done_cnt = 0; done_at = -1; acc_at_done = '0;
    @(negedge CLK);
    a = ta; b = tb_v; start = 1'b1; clr_acc = tclr;
    @(posedge CLK); #1;
    a = ~ta; b = ~tb_v; clr_acc = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      start = (k == restart_at);
      if (busy) busy_cyc++;
      if (done) begin done_cnt++; done_at = k; acc_at_done = acc_out; end
      if (!busy) break;
      @(posedge CLK); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_cmp++;
    if ({busy, done, ovf, acc_out} !== 15'd0) begin
      n_err++; $display("FAIL reset_outputs: got busy=%0b done=%0b ovf=%0b acc=%0d, want all 0", busy, done, ovf, acc_out);
    end
    @(negedge CLK); CLR = 1'b1;
    @(posedge CLK); #1;
    n_cmp++;
    if ({busy, done, ovf, acc_out} !== 15'd0) begin
      n_err++; $display("FAIL idle_after_reset: got busy=%0b done=%0b ovf=%0b acc=%0d, want all 0", busy, done, ovf, acc_out);
    end
  endtask

  task automatic test_basic;
    int bc, dc, da; logic [11:0] ad;
    run_op(4'd3, 4'd5, 1'b0, 0, bc, dc, da, ad);
    n_cmp++; if (bc !== 6) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 6", bc); end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", dc); end
    n_cmp++; if (da !== 6) begin n_err++; $display("FAIL basic_done_cycle: got %0d want 6", da); end
    n_cmp++; if (ad !== 12'd15) begin n_err++; $display("FAIL basic_acc_at_done: got %0d want 15", ad); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %0b want 0", ovf); end
  endtask

  task automatic test_ignore_start;
    int bc, dc, da; logic [11:0] ad;
    run_op(4'd15, 4'd15, 1'b0, 2, bc, dc, da, ad);
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL busy_start_done_count: got %0d want 1", dc); end
    n_cmp++; if (bc !== 6) begin n_err++; $display("FAIL busy_start_busy_cycles: got %0d want 6", bc); end
    n_cmp++; if (ad !== 12'd240) begin n_err++; $display("FAIL busy_start_acc_at_done: got %0d want 240", ad); end
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if (busy !== 1'b0 || acc_out !== 12'd240) begin
      n_err++; $display("FAIL busy_start_no_rerun: got busy=%0b acc=%0d want busy=0 acc=240", busy, acc_out);
    end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL busy_start_ovf: got %0b want 0", ovf); end
  endtask

  task automatic test_clr_and_start;
    int bc, dc, da; logic [11:0] ad;
    run_op(4'd2, 4'd7, 1'b1, 0, bc, dc, da, ad);
    n_cmp++; if (ad !== 12'd14) begin n_err++; $display("FAIL clr_start_acc: got %0d want 14", ad); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL clr_start_ovf: got %0b want 0", ovf); end
  endtask

  task automatic test_overflow;
    int bc, dc, da; logic [11:0] ad;
    run_op(4'd15, 4'd15, 1'b1, 0, bc, dc, da, ad);
    for (int i = 2; i <= 18; i++) run_op(4'd15, 4'd15, 1'b0, 0, bc, dc, da, ad);
    n_cmp++; if (acc_out !== 12'd4050) begin n_err++; $display("FAIL ovf_acc_18: got %0d want 4050", acc_out); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_flag_18: got %0b want 0", ovf); end
    run_op(4'd15, 4'd15, 1'b0, 0, bc, dc, da, ad);
    n_cmp++; if (ad !== 12'd179) begin n_err++; $display("FAIL ovf_acc_19: got %0d want 179", ad); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag_19: got %0b want 1", ovf); end
    run_op(4'd1, 4'd1, 1'b0, 0, bc, dc, da, ad);
    n_cmp++; if (ad !== 12'd180) begin n_err++; $display("FAIL ovf_acc_20: got %0d want 180", ad); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0b want 1", ovf); end
  endtask

  task automatic test_async_abort;
    int bc, dc, da; logic [11:0] ad;
    run_op(4'd2, 4'd7, 1'b1, 0, bc, dc, da, ad);
    n_cmp++; if (acc_out !== 12'd14) begin n_err++; $display("FAIL abort_setup_acc: got %0d want 14", acc_out); end
    @(negedge CLK);
    a = 4'd9; b = 4'd9; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_before: got %0b want 1", busy); end
    CLR = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, ovf, acc_out} !== 15'd0) begin
      n_err++; $display("FAIL abort_async_clear: got busy=%0b done=%0b ovf=%0b acc=%0d, want all 0", busy, done, ovf, acc_out);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK); CLR = 1'b1;
    run_op(4'd1, 4'd1, 1'b0, 0, bc, dc, da, ad);
    n_cmp++; if (ad !== 12'd1) begin n_err++; $display("FAIL abort_recover_acc: got %0d want 1", ad); end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL abort_recover_done: got %0d want 1", dc); end
  endtask

  task automatic test_zero_operands;
    int bc, dc, da; logic [11:0] ad;
    run_op(4'd0, 4'd0, 1'b1, 0, bc, dc, da, ad);
    n_cmp++; if (bc !== 6) begin n_err++; $display("FAIL zero_busy_cycles: got %0d want 6", bc); end
    n_cmp++; if (da !== 6) begin n_err++; $display("FAIL zero_done_cycle: got %0d want 6", da); end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL zero_done_count: got %0d want 1", dc); end
    n_cmp++; if (ad !== 12'd0) begin n_err++; $display("FAIL zero_acc: got %0d want 0", ad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_clr_and_start();
    test_overflow();
    test_async_abort();
    test_zero_operands();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_seq_acc.md
Name: mac_seq_acc

Overview:
Sequential shift-and-add multiply-accumulate stage that consumes the single-bit register cells of the logic-module datapath.
- Takes two unsigned N-bit operands on a start strobe and forms their product over N cycles, one multiplier bit per cycle.
- Adds the product into a wide running accumulator.
- Reports completion with a one-cycle done pulse, and flags accumulator wrap-around.

Parameters:
N, 4, operand width in bits (unsigned).
ACC_W, 12, accumulator width in bits; must be >= 2*N.

Ports:
CLK  input  1  sole clock; all state updates on the rising edge.
CLR  input  1  asynchronous, active-low reset; all state is cleared while CLR=0.
start  input  1  request one multiply-accumulate; sampled only in IDLE.
clr_acc  input  1  synchronous clear of acc_out and ovf; sampled only in IDLE.
a  input  N  multiplicand; latched when start is accepted.
b  input  N  multiplier; latched when start is accepted.
busy  output  1  high in every state other than IDLE.
done  output  1  one-cycle pulse; acc_out already holds the new sum.
acc_out  output  ACC_W  running accumulator value.
ovf  output  1  sticky flag: an accumulate carried out of ACC_W bits.

Behaviour:
- Reset (CLR=0, asynchronous): state goes to IDLE; busy=0, done=0, acc_out=0, ovf=0; internal multiplicand, multiplier, partial product and bit counter all go to 0. Reset mid-operation aborts the operation with no partial update to acc_out.
- Registered outputs: busy, done, acc_out and ovf are registered and decoded from state; no combinational path from inputs to outputs.
- FSM states: IDLE, MUL, ACC, DONE.
- IDLE:
  - If clr_acc=1: acc_out <= 0 and ovf <= 0.
  - If start=1: latch a and b, set partial product to 0 and counter to 0, then go to MUL.
  - If clr_acc and start are both 1: both take effect; the new product accumulates onto 0.
- MUL, one step per cycle:
  - If the multiplier LSB is 1, add the multiplicand shifted left by the counter into the 2N-bit partial product.
  - Shift the multiplier right by 1 and increment the counter.
  - After N steps (counter = N-1 on the last step), go to ACC.
- ACC:
  - {carry, acc_out} <= acc_out + zero-extended product.
  - If carry=1, set ovf to 1. ovf stays set until clr_acc or reset.
  - acc_out wraps modulo 2^ACC_W.
  - Go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Latency: with start accepted at edge t, done is high in the cycle following edge t+N+1, and acc_out is valid in that same cycle. The next start can be accepted at edge t+N+3.
- start and clr_acc are ignored while busy=1; there is no queuing.
- Operand values of 0 still take the full N MUL cycles, giving constant latency.
- a and b may change freely after acceptance without affecting the result.

Decomposition:
- Package mac_pkg holds:
  - the state enumeration (IDLE, MUL, ACC, DONE);
  - default width constants N_DEF=4 and ACC_W_DEF=12.
- Sub-module mac_shift_add holds the multiplicand/multiplier/partial-product registers and the per-step conditional add.
  - Controls: load, step.
  - Output: the product.
- mac_seq_acc keeps the FSM, counter, accumulator and ovf flag.

Test Plan:
1. Reset, then start with a=3, b=5 -> busy high for 6 cycles (MUL×4, ACC, DONE); done pulses once in cycle 6 after acceptance; acc_out=15; ovf=0.
2. Then start with a=15, b=15 -> acc_out=240; ovf=0. Assert start again during MUL -> ignored, exactly one done pulse, acc_out stays 240.
3. In IDLE with acc_out=240, assert clr_acc and start together with a=2, b=7 -> acc_out=14 at done; ovf=0.
4. Clear, then run 19 operations of a=15, b=15 -> acc_out=4050 after 18 operations with ovf=0; after the 19th, acc_out=179 and ovf=1. One more operation of a=1, b=1 -> acc_out=180 and ovf stays 1.
5. With acc_out=14, start a=9, b=9 and pull CLR low in the second MUL cycle -> busy, done, acc_out and ovf go to 0 immediately, asynchronously. After CLR is released, a start with a=1, b=1 yields acc_out=1.
6. a=0, b=0 with acc_out=0 -> latency is still 6 cycles; acc_out=0; done pulses once.
